// File: rtl/phase_step_decoder.sv
// Recovers the DDS tuning word from a modulo-MAX_PHASE phase stream.
// Locks after LOCK_CNT equal steps and flags step errors while locked.
module phase_step_decoder #(
    parameter int PHASE_W   = 14,
    parameter int M_W       = 13,
    parameter int MAX_PHASE = 10000,
    parameter int LOCK_CNT  = 8,
    parameter int LOSS_CNT  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHASE_W-1:0] phase_in,
    input  logic               phase_valid,
    output logic [M_W-1:0]     m_out,
    output logic               locked,
    output logic               err
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int LC_W = $clog2(LOSS_CNT + 1);
    localparam logic [PHASE_W:0] MAX_V  = (PHASE_W+1)'(MAX_PHASE);
    localparam logic [MC_W-1:0]  LOCK_V = MC_W'(LOCK_CNT);
    localparam logic [LC_W-1:0]  LOSS_V = LC_W'(LOSS_CNT);

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED} state_t;

    state_t             state, state_nxt;
    logic [PHASE_W-1:0] prev, prev_nxt;
    logic [M_W-1:0]     cand, cand_nxt, m_nxt;
    logic               cand_valid, cv_nxt, locked_nxt, err_nxt;
    logic [MC_W-1:0]    match_cnt, match_nxt;
    logic [LC_W-1:0]    miss_cnt, miss_nxt;

    logic [PHASE_W:0]   phase_x, prev_x, delta;
    logic [M_W-1:0]     delta_m;
    logic               legal, illegal, in_range, m_hit;
    logic [M_W-1:0]     acq_cand;
    logic               acq_cv, acq_lock;
    logic [MC_W-1:0]    acq_match;
    logic [LC_W-1:0]    miss_inc;

    // Delta in PHASE_W+1 bits; prev is always a legal phase so the wrap branch stays < MAX_PHASE.
    assign phase_x  = {1'b0, phase_in};
    assign prev_x   = {1'b0, prev};
    assign legal    = phase_valid && (phase_x < MAX_V);
    assign illegal  = phase_valid && !(phase_x < MAX_V);
    assign delta    = (phase_x >= prev_x) ? phase_x - prev_x : phase_x + MAX_V - prev_x;
    assign delta_m  = delta[M_W-1:0];
    assign in_range = (delta >> M_W) == '0;
    assign m_hit    = in_range && (delta_m == m_out);
    assign miss_inc = miss_cnt + 1'b1;

    // Candidate tracking while acquiring.
    always_comb begin
        acq_cand  = cand;
        acq_cv    = 1'b0;
        acq_match = '0;
        if (in_range) begin
            acq_cv = 1'b1;
            if (cand_valid && delta_m == cand) begin
                acq_match = match_cnt + 1'b1;
            end else begin
                acq_cand  = delta_m;
                acq_match = MC_W'(1);
            end
        end
        acq_lock = (acq_match == LOCK_V);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (illegal) begin
            state_nxt = S_IDLE;
        end else if (phase_valid) begin
            case (state)
                S_IDLE:   state_nxt = S_ACQ;
                S_ACQ:    if (acq_lock) state_nxt = S_LOCKED;
                S_LOCKED: if (!m_hit && miss_inc == LOSS_V) state_nxt = S_ACQ;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        prev_nxt   = prev;
        cand_nxt   = cand;
        cv_nxt     = cand_valid;
        match_nxt  = match_cnt;
        miss_nxt   = miss_cnt;
        m_nxt      = m_out;
        locked_nxt = locked;
        err_nxt    = 1'b0;
        if (illegal) begin
            err_nxt    = 1'b1;
            locked_nxt = 1'b0;
            cv_nxt     = 1'b0;
            match_nxt  = '0;
            miss_nxt   = '0;
        end else if (legal) begin
            prev_nxt = phase_in;
            case (state)
                S_ACQ: begin
                    cand_nxt  = acq_cand;
                    cv_nxt    = acq_cv;
                    match_nxt = acq_match;
                    if (acq_lock) begin
                        m_nxt      = acq_cand;
                        locked_nxt = 1'b1;
                        miss_nxt   = '0;
                    end
                end
                S_LOCKED: begin
                    if (m_hit) begin
                        miss_nxt = '0;
                    end else begin
                        err_nxt  = 1'b1;
                        miss_nxt = miss_inc;
                        // Dropping lock restarts acquisition with this delta as the first match.
                        if (miss_inc == LOSS_V) begin
                            locked_nxt = 1'b0;
                            miss_nxt   = '0;
                            cand_nxt   = in_range ? delta_m : cand;
                            cv_nxt     = in_range;
                            match_nxt  = in_range ? MC_W'(1) : '0;
                        end
                    end
                end
                default: begin
                    cv_nxt    = 1'b0;
                    match_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev       <= '0;
            cand       <= '0;
            cand_valid <= 1'b0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            m_out      <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
        end else begin
            prev       <= prev_nxt;
            cand       <= cand_nxt;
            cand_valid <= cv_nxt;
            match_cnt  <= match_nxt;
            miss_cnt   <= miss_nxt;
            m_out      <= m_nxt;
            locked     <= locked_nxt;
            err        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_phase_step_decoder.sv
// Directed bench for phase_step_decoder: lock, wrap, glitch/loss, illegal,
// out-of-range, M=0, async reset and gapped-valid streams.
module tb_phase_step_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] phase_in;
    logic        phase_valid;
    logic [12:0] m_out;
    logic        locked;
    logic        err;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;

    phase_step_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .phase_in    (phase_in),
        .phase_valid (phase_valid),
        .m_out       (m_out),
        .locked      (locked),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Drive on negedge, sample 1 time unit after the consuming posedge.
    task automatic step(input logic v, input int p);
        @(negedge clk);
        phase_valid = v;
        phase_in    = 14'(p);
        @(posedge clk);
        #1;
        if (err) err_seen++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        phase_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        err_seen = 0;
    endtask

    initial begin
        rst_n       = 1'b0;
        phase_valid = 1'b0;
        phase_in    = '0;
        #12;
        chk("rst_locked", locked, 0);
        chk("rst_m_out", m_out, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: clean M=123 stream locks on the 9th sample
        err_seen = 0;
        for (int k = 0; k < 9; k++) begin
            step(1'b1, k * 123);
            if (k == 7) chk("t1_not_yet", locked, 0);
        end
        chk("t1_locked", locked, 1);
        chk("t1_m_out", m_out, 123);
        chk("t1_no_err", err_seen, 0);

        // 2: wrap through the modulus with M=15
        do_reset();
        for (int k = 0; k < 9; k++) step(1'b1, 9840 + 15 * k);
        chk("t2_locked", locked, 1);
        step(1'b1, 9975);
        step(1'b1, 9990);
        step(1'b1, 5);
        step(1'b1, 20);
        chk("t2_no_err", err_seen, 0);
        chk("t2_still_locked", locked, 1);
        chk("t2_m_out", m_out, 15);

        // 3: single glitch keeps lock, frequency change drops and relocks
        do_reset();
        for (int k = 0; k <= 10; k++) step(1'b1, k * 123);
        err_seen = 0;
        step(1'b1, 7777);
        chk("t3_glitch_err", err, 1);
        step(1'b1, 1476);
        step(1'b1, 1599);
        chk("t3_glitch_pulses", err_seen, 2);
        chk("t3_glitch_locked", locked, 1);
        chk("t3_glitch_m", m_out, 123);
        err_seen = 0;
        step(1'b1, 1799);
        step(1'b1, 1999);
        chk("t3_loss_pending", locked, 1);
        step(1'b1, 2199);
        chk("t3_loss_pulses", err_seen, 3);
        chk("t3_lost", locked, 0);
        chk("t3_m_held", m_out, 123);
        err_seen = 0;
        for (int j = 1; j <= 7; j++) begin
            step(1'b1, 2199 + 200 * j);
            if (j == 6) chk("t3_relock_not_yet", locked, 0);
        end
        chk("t3_relocked", locked, 1);
        chk("t3_relock_m", m_out, 200);
        chk("t3_relock_no_err", err_seen, 0);

        // 4: illegal sample while locked
        step(1'b1, 10000);
        chk("t4_err", err, 1);
        chk("t4_unlocked", locked, 0);
        step(1'b0, 0);
        chk("t4_err_clear", err, 0);
        err_seen = 0;
        step(1'b1, 500);
        chk("t4_first_legal", locked, 0);
        for (int j = 1; j <= 8; j++) begin
            step(1'b1, 500 + 50 * j);
            if (j == 7) chk("t4_not_yet", locked, 0);
        end
        chk("t4_relocked", locked, 1);
        chk("t4_m_out", m_out, 50);
        chk("t4_no_err", err_seen, 0);

        // 5: out-of-range deltas never lock; constant phase locks with M=0
        do_reset();
        step(1'b1, 0);
        step(1'b1, 9000);
        step(1'b1, 8000);
        chk("t5_no_lock", locked, 0);
        for (int j = 0; j < 9; j++) begin
            step(1'b1, 42);
            if (j == 7) chk("t5_not_yet", locked, 0);
        end
        chk("t5_locked", locked, 1);
        chk("t5_m_zero", m_out, 0);
        chk("t5_no_err", err_seen, 0);

        // 6: async reset mid-cycle, then a 1-in-3 gapped stream
        do_reset();
        for (int k = 0; k < 9; k++) step(1'b1, k * 123);
        chk("t6_locked", locked, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_locked", locked, 0);
        chk("t6_async_m", m_out, 0);
        rst_n = 1'b1;
        step(1'b1, 10000);
        chk("t6_illegal_err", err, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_err", err, 0);
        rst_n = 1'b1;
        err_seen = 0;
        for (int k = 0; k < 9; k++) begin
            step(1'b1, k * 77);
            if (k == 7) chk("t6_gap_not_yet", locked, 0);
            if (k < 8) begin
                step(1'b0, 16383);
                step(1'b0, 16383);
            end
        end
        chk("t6_gap_locked", locked, 1);
        chk("t6_gap_m", m_out, 77);
        chk("t6_gap_no_err", err_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
